// File: rtl/bbpd_dlf_pmix_pkg.sv
// ============================================================================
// Module      : bbpd_dlf_pmix_pkg
// Description : Shared defaults, types and Alexander decision helper for the
//               bang-bang CDR (phase detector, loop filter, interpolator).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bbpd_dlf_pmix_pkg;

  localparam int C_CODE_W   = 11;
  localparam int C_NOM_STEP = 128;
  localparam int C_KP       = 4;
  localparam int C_KI       = 1;
  localparam int C_INT_W    = 12;
  localparam int C_FRAC     = 4;

  typedef logic        [C_CODE_W-1:0] code_t;
  typedef logic signed [C_INT_W-1:0]  integ_t;

  typedef enum logic [1:0] {
    PD_NONE = 2'b00,
    PD_UP   = 2'b01,
    PD_DN   = 2'b10
  } pd_dir_e;

  // With a transition present, the edge sample matches exactly one of the two
  // data samples: matching the new one means the clock is late.
  function automatic pd_dir_e alex_decide(
    input logic d_prev,
    input logic e_smp,
    input logic d_new
  );
    pd_dir_e dir;
    if (d_prev == d_new) begin
      dir = PD_NONE;
    end else if (e_smp == d_new) begin
      dir = PD_UP;
    end else begin
      dir = PD_DN;
    end
    return dir;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bbpd_core.sv
// ============================================================================
// Module      : bbpd_core
// Description : Alexander bang-bang phase detector: data/edge sampling of Din
//               and registered one-clk Up/Dn decision pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbpd_core
  import bbpd_dlf_pmix_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  input  logic data_evt_i,
  input  logic edge_evt_i,
  output logic dout_o,
  output logic up_o,
  output logic dn_o
);

  logic    d_q;
  logic    d_prev_q;
  logic    e_q;
  logic    data_evt_q;
  logic    up_q;
  logic    dn_q;
  pd_dir_e dir_w;

  assign dir_w = alex_decide(d_prev_q, e_q, d_q);

  // The decision is taken one clk after the data event, from the registered
  // samples, so the pulse lands exactly one clk after the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q        <= 1'b0;
      d_prev_q   <= 1'b0;
      e_q        <= 1'b0;
      data_evt_q <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
    end else begin
      data_evt_q <= data_evt_i;
      if (data_evt_i) begin
        d_q      <= din_i;
        d_prev_q <= d_q;
      end
      if (edge_evt_i) begin
        e_q <= din_i;
      end
      up_q <= data_evt_q && (dir_w == PD_UP);
      dn_q <= data_evt_q && (dir_w == PD_DN);
    end
  end

  assign dout_o = d_q;
  assign up_o   = up_q;
  assign dn_o   = dn_q;

endmodule

`default_nettype wire

// File: rtl/bbpd_dlf_pmix.sv
// ============================================================================
// Module      : bbpd_dlf_pmix
// Description : Bang-bang CDR: phase interpolator (reference accumulator plus
//               code), Alexander detector and digital loop filter. Define
//               DLF_INTEGRAL_PATH_EN to add the saturating integral path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbpd_dlf_pmix
  import bbpd_dlf_pmix_pkg::*;
#(
  parameter int CODE_W   = C_CODE_W,
  parameter int NOM_STEP = C_NOM_STEP,
  parameter int KP       = C_KP,
  parameter int KI       = C_KI,
  parameter int INT_W    = C_INT_W,
  parameter int FRAC     = C_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Din,
  output logic              PI_Clk,
  output logic              Dout,
  output logic              Up,
  output logic              Dn,
  output logic [CODE_W-1:0] code
);

  localparam logic [CODE_W-1:0] C_STEP = CODE_W'(NOM_STEP);
  localparam logic [CODE_W-1:0] C_KP_V = CODE_W'(KP);

  if (NOM_STEP < 1 || NOM_STEP >= 2**(CODE_W-1) || KP < 0 || KI < 0 ||
      FRAC < 0 || INT_W <= FRAC || CODE_W < 2) begin : g_bad_param
    $error("bbpd_dlf_pmix: inconsistent parameter set");
  end

  logic [CODE_W-1:0] ref_q;
  logic [CODE_W-1:0] ref_d;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_d;
  logic [CODE_W-1:0] phase_w;
  logic [CODE_W-1:0] int_contrib_w;
  logic              pi_q;
  logic              pi_d;
  logic              data_evt_w;
  logic              edge_evt_w;
  logic              up_w;
  logic              dn_w;

  // PI_Clk is registered from the phase the accumulator is about to take, so
  // the first rise after reset follows 2^(CODE_W-1)/NOM_STEP clks.
  assign ref_d      = ref_q + C_STEP;
  assign phase_w    = ref_d + code_q;
  assign pi_d       = phase_w[CODE_W-1];
  assign data_evt_w = pi_d & ~pi_q;
  assign edge_evt_w = ~pi_d & pi_q;

  bbpd_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_i      (Din),
    .data_evt_i (data_evt_w),
    .edge_evt_i (edge_evt_w),
    .dout_o     (Dout),
    .up_o       (up_w),
    .dn_o       (dn_w)
  );

`ifdef DLF_INTEGRAL_PATH_EN
  localparam logic signed [INT_W:0] C_IMAX = (INT_W+1)'((2**(INT_W-1)) - 1);
  localparam logic signed [INT_W:0] C_IMIN = -C_IMAX;
  localparam logic signed [INT_W:0] C_KI_V = (INT_W+1)'(KI);

  logic signed [INT_W-1:0] integ_q;
  logic signed [INT_W-1:0] integ_d;
  logic signed [INT_W-1:0] integ_shr_w;
  logic signed [INT_W:0]   integ_sum_w;

  // One guard bit lets the +/-KI step be clamped symmetrically.
  always_comb begin
    integ_sum_w = {integ_q[INT_W-1], integ_q};
    if (up_w) begin
      integ_sum_w = integ_sum_w + C_KI_V;
    end else if (dn_w) begin
      integ_sum_w = integ_sum_w - C_KI_V;
    end
    if (integ_sum_w > C_IMAX) begin
      integ_d = C_IMAX[INT_W-1:0];
    end else if (integ_sum_w < C_IMIN) begin
      integ_d = C_IMIN[INT_W-1:0];
    end else begin
      integ_d = integ_sum_w[INT_W-1:0];
    end
  end

  assign integ_shr_w   = integ_d >>> FRAC;
  assign int_contrib_w = CODE_W'(integ_shr_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '0;
    end else begin
      integ_q <= integ_d;
    end
  end
`else
  assign int_contrib_w = '0;
`endif

  // Code wraps freely: a full turn of the code is one UI of phase.
  always_comb begin
    code_d = code_q;
    if (up_w) begin
      code_d = code_q + C_KP_V + int_contrib_w;
    end else if (dn_w) begin
      code_d = code_q - C_KP_V + int_contrib_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q  <= '0;
      code_q <= '0;
      pi_q   <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      code_q <= code_d;
      pi_q   <= pi_d;
    end
  end

  assign PI_Clk = pi_q;
  assign Up     = up_w;
  assign Dn     = dn_w;
  assign code   = code_q;

endmodule

`default_nettype wire

// File: tb/tb_bbpd_dlf_pmix.sv
// ============================================================================
// Module      : tb_bbpd_dlf_pmix
// Description : Self-checking bench for bbpd_dlf_pmix against a phase-level
//               reference model; honours DLF_INTEGRAL_PATH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bbpd_dlf_pmix;

  localparam int CW    = 11;
  localparam int NOM   = 128;
  localparam int KP    = 4;
  localparam int KI    = 1;
  localparam int INT_W = 12;
  localparam int FRAC  = 4;
  localparam int MOD   = 1 << CW;
  localparam int HALF  = 1 << (CW - 1);
  localparam int IMAX  = (1 << (INT_W - 1)) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          Din   = 1'b0;
  logic          PI_Clk;
  logic          Dout;
  logic          Up;
  logic          Dn;
  logic [CW-1:0] code;

  int    total = 0;
  int    bad   = 0;
  string phase_name = "reset";

  // reference model state
  int   m_ref;
  int   m_code;
  int   m_integ;
  int   pend_dir;
  int   vis_dir;
  logic m_pi;
  logic m_d;
  logic m_e;

  always #5 clk = ~clk;

  bbpd_dlf_pmix #(
    .CODE_W   (CW),
    .NOM_STEP (NOM),
    .KP       (KP),
    .KI       (KI),
    .INT_W    (INT_W),
    .FRAC     (FRAC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Din    (Din),
    .PI_Clk (PI_Clk),
    .Dout   (Dout),
    .Up     (Up),
    .Dn     (Dn),
    .code   (code)
  );

  function automatic int wrap(input int x);
    return ((x % MOD) + MOD) % MOD;
  endfunction

  function automatic logic msb_of(input int x);
    return wrap(x) >= HALF;
  endfunction

  function automatic int sdist(input int x);
    int w;
    w = wrap(x);
    return (w >= HALF) ? w - MOD : w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ref = 0; m_code = 0; m_integ = 0; pend_dir = 0; vis_dir = 0;
    m_pi = 1'b0; m_d = 1'b0; m_e = 1'b0;
  endtask

  // Phase of the interpolated clock is ref + code; a pulse seen during a clk
  // moves the code at the end of that clk.
  task automatic model_edge(input logic din);
    int   old_code;
    logic pi_new;
    old_code = m_code;
    if (vis_dir != 0) begin
`ifdef DLF_INTEGRAL_PATH_EN
      m_integ = m_integ + vis_dir * KI;
      if (m_integ > IMAX)  m_integ = IMAX;
      if (m_integ < -IMAX) m_integ = -IMAX;
`endif
      m_code = wrap(m_code + vis_dir * KP + (m_integ >>> FRAC));
    end
    m_ref   = wrap(m_ref + NOM);
    pi_new  = msb_of(m_ref + old_code);
    vis_dir = pend_dir;
    pend_dir = 0;
    if (pi_new && !m_pi) begin
      if (m_d != din) pend_dir = (m_e == din) ? 1 : -1;
      m_d = din;
    end
    if (!pi_new && m_pi) m_e = din;
    m_pi = pi_new;
  endtask

  task automatic check_outputs();
    chk({phase_name, " PI_Clk"}, 32'(PI_Clk), 32'(m_pi));
    chk({phase_name, " Dout"},   32'(Dout),   32'(m_d));
    chk({phase_name, " Up"},     32'(Up),     32'(vis_dir == 1));
    chk({phase_name, " Dn"},     32'(Dn),     32'(vis_dir == -1));
    chk({phase_name, " code"},   32'(code),   32'(m_code));
    chk({phase_name, " Up&Dn"},  32'(Up & Dn), 32'd0);
  endtask

  task automatic tick(input logic din);
    @(negedge clk);
    Din = din;
    @(posedge clk);
    if (rst_n) model_edge(din);
    #1;
    check_outputs();
  endtask

  initial begin
    logic       cur;
    logic       prev_pi;
    logic       bitv;
    logic [6:0] lfsr;
    int         n_tog, last_tog, up_cnt, dn_cnt, hi_cnt;
    int         first_rise, last_rise, q, start_off, prev_idx;
    int         c0, dmin, dmax, dv;

    // ---- reset held for 5 clk
    model_reset();
    rst_n = 1'b0;
    repeat (5) tick(1'b0);
    rst_n = 1'b1;

    // ---- static data, 100 UI
    phase_name = "static";
    first_rise = -1; last_rise = -1; prev_pi = 1'b0; up_cnt = 0; dn_cnt = 0; hi_cnt = 0;
    for (int i = 1; i <= 1600; i++) begin
      tick(1'b0);
      if (PI_Clk === 1'b1) hi_cnt++;
      if (Up === 1'b1) up_cnt++;
      if (Dn === 1'b1) dn_cnt++;
      if (PI_Clk === 1'b1 && prev_pi === 1'b0) begin
        if (first_rise < 0) first_rise = i;
        else chk("static rise period", 32'(i - last_rise), 32'd16);
        last_rise = i;
      end
      prev_pi = PI_Clk;
    end
    chk("first rise after release", 32'(first_rise), 32'd8);
    chk("static high clks", 32'(hi_cnt), 32'd800);
    chk("static up count", 32'(up_cnt), 32'd0);
    chk("static dn count", 32'(dn_cnt), 32'd0);
    chk("static code", 32'(code), 32'd0);

    // ---- late clock: transition ~2 clk before the edge sample
    phase_name = "late";
    cur = 1'b0; n_tog = 0; last_tog = -100; up_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 824; i++) begin
      q = wrap(m_ref + m_code);
      if (i < 800 && i - last_tog > 8 && msb_of(q + 2*NOM) && !msb_of(q + 3*NOM)) begin
        cur = ~cur; n_tog++; last_tog = i;
      end
      tick(cur);
      if (Up === 1'b1) up_cnt++;
      if (Dn === 1'b1) dn_cnt++;
    end
    chk("late up pulses", 32'(up_cnt), 32'(n_tog));
    chk("late dn pulses", 32'(dn_cnt), 32'd0);
`ifndef DLF_INTEGRAL_PATH_EN
    chk("late code", 32'(code), 32'(wrap(KP * n_tog)));
`endif

    // ---- asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst PI_Clk", 32'(PI_Clk), 32'd0);
    chk("async rst Dout", 32'(Dout), 32'd0);
    chk("async rst Up", 32'(Up), 32'd0);
    chk("async rst Dn", 32'(Dn), 32'd0);
    chk("async rst code", 32'(code), 32'd0);
    phase_name = "reset2";
    model_reset();
    repeat (3) tick(1'b0);
    rst_n = 1'b1;

    // ---- early clock: transition ~2 clk after the edge sample
    phase_name = "early";
    cur = 1'b0; n_tog = 0; last_tog = -100; up_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 824; i++) begin
      q = wrap(m_ref + m_code);
      if (i >= 16 && i < 800 && i - last_tog > 8 && msb_of(q - 2*NOM) && !msb_of(q - NOM)) begin
        cur = ~cur; n_tog++; last_tog = i;
      end
      tick(cur);
      if (Up === 1'b1) up_cnt++;
      if (Dn === 1'b1) dn_cnt++;
    end
    chk("early dn pulses", 32'(dn_cnt), 32'(n_tog));
    chk("early up pulses", 32'(up_cnt), 32'd0);
`ifndef DLF_INTEGRAL_PATH_EN
    chk("early code", 32'(code), 32'(wrap(-KP * n_tog)));
`endif

    // ---- lock: PRBS7 at 16 clk/bit with random start phase
    phase_name = "lock";
    lfsr = 7'($urandom_range(1, 126));
    start_off = $urandom_range(0, 15);
    repeat (start_off) tick(cur);
    prev_pi = PI_Clk; prev_idx = -1; c0 = 0; dmin = 0; dmax = 0;
    for (int b = 0; b < 1050; b++) begin
      bitv = lfsr[6];
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      for (int k = 0; k < 16; k++) begin
        tick(bitv);
        if (b == 900 && k == 0) c0 = int'(code);
        if (b >= 900) begin
          dv = sdist(int'(code) - c0);
          if (dv < dmin) dmin = dv;
          if (dv > dmax) dmax = dv;
          if (PI_Clk === 1'b1 && prev_pi === 1'b0) begin
            if (prev_idx >= 0) chk("lock sample index", 32'(b), 32'(prev_idx + 1));
            chk("lock dout", 32'(Dout), 32'(bitv));
            prev_idx = b;
          end
        end
        prev_pi = PI_Clk;
      end
    end
`ifndef DLF_INTEGRAL_PATH_EN
    chk("lock code span ok", 32'((dmax - dmin) <= 16), 32'd1);
`endif

`ifdef DLF_INTEGRAL_PATH_EN
    // ---- frequency offset: 15.9 clk/bit average
    phase_name = "freq";
    prev_idx = 0;
    bitv = lfsr[6];
    for (int t = 0; t < 19080; t++) begin
      if ((t * 10) / 159 != prev_idx) begin
        prev_idx = (t * 10) / 159;
        lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        bitv = lfsr[6];
      end
      tick(bitv);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
